chacha_sequencer: RTL

Control FSM for the ChaCha20 block core. It does three jobs:
- Turns the host byte-serial strobes (wr_key/wr_nnc/wr_ctr/rd_blk) into state-load addresses and enables.
- Schedules the round sequence (column/diagonal half-rounds), the feed-forward add and the block counter increment.
- Owns blk_ready and the read address.

It sits between the chip-level I/O and the four quarter-round columns. It handles no data bytes itself; the core muxes data_in and data_out.

---
 rtl/chacha_sequencer_if.sv | 55 +++++
 rtl/chacha_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chacha_sequencer_if.sv
// ---------------------------------------------------------------------------
// chacha_sequencer_if
// Groups the signals between the ChaCha20 sequencer, the host byte-serial
// strobes and the quarter-round core.
//   host -> seq : wr_key, wr_nnc, wr_ctr, rd_blk
//   seq -> host : blk_ready, busy
//   seq -> core : ld_en, ld_addr, rd_addr, init, qr_start, qr_diag,
//                 ff_start, ctr_inc
//   core -> seq : qr_done, ff_done
// Optional macro CHACHA_WATCHDOG_EN adds err (seq -> host).
// Modports: slave = the sequencer, master = its environment.
// ---------------------------------------------------------------------------
interface chacha_sequencer_if;
  logic       wr_key;
  logic       wr_nnc;
  logic       wr_ctr;
  logic       rd_blk;
  logic       blk_ready;
  logic       ld_en;
  logic [5:0] ld_addr;
  logic [5:0] rd_addr;
  logic       init;
  logic       qr_start;
  logic       qr_diag;
  logic       qr_done;
  logic       ff_start;
  logic       ff_done;
  logic       ctr_inc;
  logic       busy;
`ifdef CHACHA_WATCHDOG_EN
  logic       err;

  modport slave (
    input  wr_key, wr_nnc, wr_ctr, rd_blk, qr_done, ff_done,
    output blk_ready, ld_en, ld_addr, rd_addr, init, qr_start, qr_diag,
           ff_start, ctr_inc, busy, err
  );
  modport master (
    output wr_key, wr_nnc, wr_ctr, rd_blk, qr_done, ff_done,
    input  blk_ready, ld_en, ld_addr, rd_addr, init, qr_start, qr_diag,
           ff_start, ctr_inc, busy, err
  );
`else
  modport slave (
    input  wr_key, wr_nnc, wr_ctr, rd_blk, qr_done, ff_done,
    output blk_ready, ld_en, ld_addr, rd_addr, init, qr_start, qr_diag,
           ff_start, ctr_inc, busy
  );
  modport master (
    output wr_key, wr_nnc, wr_ctr, rd_blk, qr_done, ff_done,
    input  blk_ready, ld_en, ld_addr, rd_addr, init, qr_start, qr_diag,
           ff_start, ctr_inc, busy
  );
`endif
endinterface

// File: rtl/chacha_sequencer.sv
// ---------------------------------------------------------------------------
// chacha_sequencer
// Control FSM for the ChaCha20 block core: turns host load strobes into
// state-byte write addresses, schedules the 2*DOUBLE_ROUNDS half-rounds
// (column/diagonal alternating), the feed-forward add and the block
// counter increment, and owns blk_ready / rd_addr for block readout.
// Ports:
//   clk  - clock
//   rst  - synchronous reset, active-high
//   bus  - chacha_sequencer_if.slave (host strobes, core handshakes)
// Optional feature: define CHACHA_WATCHDOG_EN to add bus.err and a
// TIMEOUT_CYCLES watchdog on every qr_done / ff_done handshake.
// ---------------------------------------------------------------------------
module chacha_sequencer #(
  parameter int DOUBLE_ROUNDS = 10
`ifdef CHACHA_WATCHDOG_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic               clk,
  input  logic               rst,
  chacha_sequencer_if.slave  bus
);

  localparam int            CW      = $clog2(2 * DOUBLE_ROUNDS + 1);
  localparam logic [CW-1:0] LAST_HR = CW'(2 * DOUBLE_ROUNDS - 1);
`ifdef CHACHA_WATCHDOG_EN
  localparam logic [7:0]    WD_LAST = 8'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_INIT = 3'd1, S_ROUND = 3'd2, S_FEEDFWD = 3'd3, S_READY = 3'd4
  } state_e;

  typedef enum logic [1:0] {R_KEY = 2'd0, R_NNC = 2'd1, R_CTR = 2'd2} rgn_e;

  state_e        state_q, state_d;
  logic          win_q, win_d;
  rgn_e          rgn_q, rgn_d;
  logic [5:0]    off_q, off_d;
  logic          key_v_q, key_v_d, nnc_v_q, nnc_v_d, ctr_v_q, ctr_v_d;
  logic [CW-1:0] hr_q, hr_d;
  logic          wait_q, wait_d;
  logic [5:0]    rd_addr_q, rd_addr_d;
  logic          ctr_inc_q, ctr_inc_d;
`ifdef CHACHA_WATCHDOG_EN
  logic [7:0]    wd_q, wd_d;
  logic          err_q, err_d;
`endif

  logic          win_start_s, win_end_s, in_win_s, bound_s, done_s;
  rgn_e          cur_rgn_s;
  logic [5:0]    cur_off_s, base_s, len_s;

  // State register bank
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      win_q     <= 1'b0;
      rgn_q     <= R_KEY;
      off_q     <= 6'd0;
      key_v_q   <= 1'b0;
      nnc_v_q   <= 1'b0;
      ctr_v_q   <= 1'b0;
      hr_q      <= '0;
      wait_q    <= 1'b0;
      rd_addr_q <= 6'd0;
      ctr_inc_q <= 1'b0;
`ifdef CHACHA_WATCHDOG_EN
      wd_q      <= 8'd0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      rgn_q     <= rgn_d;
      off_q     <= off_d;
      key_v_q   <= key_v_d;
      nnc_v_q   <= nnc_v_d;
      ctr_v_q   <= ctr_v_d;
      hr_q      <= hr_d;
      wait_q    <= wait_d;
      rd_addr_q <= rd_addr_d;
      ctr_inc_q <= ctr_inc_d;
`ifdef CHACHA_WATCHDOG_EN
      wd_q      <= wd_d;
      err_q     <= err_d;
`endif
    end
  end

  // Load-window decode: which region is being written and at what offset.
  // A window can only open while no other is open, in IDLE or READY.
  always_comb begin
    win_start_s = !win_q && (bus.wr_key || bus.wr_nnc || bus.wr_ctr) &&
                  (state_q == S_IDLE || state_q == S_READY);
    if (win_start_s) begin
      if (bus.wr_key)      cur_rgn_s = R_KEY;
      else if (bus.wr_nnc) cur_rgn_s = R_NNC;
      else                 cur_rgn_s = R_CTR;
      cur_off_s = 6'd0;
    end else begin
      cur_rgn_s = rgn_q;
      cur_off_s = off_q;
    end
    case (cur_rgn_s)
      R_KEY:   begin base_s = 6'd16; len_s = 6'd32; bound_s = bus.wr_key; end
      R_NNC:   begin base_s = 6'd52; len_s = 6'd12; bound_s = bus.wr_nnc; end
      R_CTR:   begin base_s = 6'd48; len_s = 6'd4;  bound_s = bus.wr_ctr; end
      default: begin base_s = 6'd0;  len_s = 6'd0;  bound_s = 1'b0;       end
    endcase
    in_win_s  = win_start_s || (win_q && bound_s);
    win_end_s = win_q && !bound_s;
    done_s    = (state_q == S_ROUND) ? bus.qr_done : bus.ff_done;
  end

  // Next-state and sequencing datapath
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    rgn_d     = rgn_q;
    off_d     = off_q;
    key_v_d   = key_v_q;
    nnc_v_d   = nnc_v_q;
    ctr_v_d   = ctr_v_q;
    hr_d      = hr_q;
    wait_d    = wait_q;
    rd_addr_d = rd_addr_q;
    ctr_inc_d = 1'b0;
`ifdef CHACHA_WATCHDOG_EN
    wd_d      = wd_q;
    err_d     = err_q;
`endif

    // Window bookkeeping; a region's flag is only trusted after a full-length window
    if (win_start_s) begin
      win_d = 1'b1;
      rgn_d = cur_rgn_s;
      off_d = 6'd1;
      case (cur_rgn_s)
        R_KEY:   key_v_d = 1'b0;
        R_NNC:   nnc_v_d = 1'b0;
        R_CTR:   ctr_v_d = 1'b0;
        default: key_v_d = key_v_q;
      endcase
    end else if (win_end_s) begin
      win_d = 1'b0;
      if (off_q == len_s) begin
        case (rgn_q)
          R_KEY:   key_v_d = 1'b1;
          R_NNC:   nnc_v_d = 1'b1;
          R_CTR:   ctr_v_d = 1'b1;
          default: key_v_d = key_v_q;
        endcase
`ifdef CHACHA_WATCHDOG_EN
        if (rgn_q == R_KEY) err_d = 1'b0;
        else                err_d = err_q;
`endif
      end else begin
        off_d = off_q;
      end
    end else if (in_win_s) begin
      if (off_q < len_s) off_d = off_q + 6'd1;
      else               off_d = off_q;
    end else begin
      win_d = win_q;
    end

    case (state_q)
      S_IDLE: begin
        if (!in_win_s && key_v_q && nnc_v_q && ctr_v_q) state_d = S_INIT;
        else                                           state_d = S_IDLE;
      end
      S_INIT: begin
        hr_d    = '0;
        wait_d  = 1'b0;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        // qr_done is only looked at after the start pulse has gone out
        if (!wait_q) begin
          wait_d = 1'b1;
        end else if (bus.qr_done) begin
          wait_d = 1'b0;
          hr_d   = hr_q + CW'(1);
          if (hr_q == LAST_HR) state_d = S_FEEDFWD;
          else                 state_d = S_ROUND;
        end else begin
          wait_d = 1'b1;
        end
      end
      S_FEEDFWD: begin
        if (!wait_q) begin
          wait_d = 1'b1;
        end else if (bus.ff_done) begin
          wait_d  = 1'b0;
          state_d = S_READY;
        end else begin
          wait_d = 1'b1;
        end
      end
      S_READY: begin
        // A new load window beats a same-cycle read
        if (win_start_s) begin
          rd_addr_d = 6'd0;
          state_d   = S_IDLE;
        end else if (bus.rd_blk) begin
          rd_addr_d = rd_addr_q + 6'd1;
          if (rd_addr_q == 6'd63) begin
            ctr_inc_d = 1'b1;
            state_d   = S_INIT;
          end else begin
            state_d = S_READY;
          end
        end else begin
          rd_addr_d = rd_addr_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef CHACHA_WATCHDOG_EN
    // Watchdog: counts wait cycles after each start pulse; expiry aborts to IDLE
    if ((state_q == S_ROUND || state_q == S_FEEDFWD) && wait_q && !done_s) begin
      if (wd_q == WD_LAST) begin
        state_d = S_IDLE;
        wait_d  = 1'b0;
        err_d   = 1'b1;
        key_v_d = 1'b0;
        nnc_v_d = 1'b0;
        ctr_v_d = 1'b0;
        wd_d    = 8'd0;
      end else begin
        wd_d = wd_q + 8'd1;
      end
    end else begin
      wd_d = 8'd0;
    end
`endif
  end

  // Output decode
  always_comb begin
    bus.blk_ready = (state_q == S_READY) && !win_start_s;
    bus.ld_en     = in_win_s && (cur_off_s < len_s);
    bus.ld_addr   = bus.ld_en ? (base_s + cur_off_s) : 6'd0;
    bus.rd_addr   = rd_addr_q;
    bus.init      = (state_q == S_INIT);
    bus.qr_start  = (state_q == S_ROUND) && !wait_q;
    bus.qr_diag   = bus.qr_start ? hr_q[0] : 1'b0;
    bus.ff_start  = (state_q == S_FEEDFWD) && !wait_q;
    bus.ctr_inc   = ctr_inc_q;
    bus.busy      = (state_q == S_INIT) || (state_q == S_ROUND) || (state_q == S_FEEDFWD);
`ifdef CHACHA_WATCHDOG_EN
    bus.err       = err_q;
`endif
  end

endmodule
